// File: rtl/conv3x3_mc_stride_stream.sv
// conv3x3_mc_stride_stream
//   Streaming valid-mode 3x3 convolution over CH packed input channels. The
//   CH per-channel results are merged into one output pixel. The window step
//   is STRIDE (1 or 2). Weights and bias can be written while no frame is in
//   progress. An optional ReLU is applied at the output.
// Ports
//   clk, reset      rising-edge clock; asynchronous active-low reset
//   valid_in        pxl_in holds one pixel of every channel (valid_in=0 stalls)
//   pxl_in          channel c at bits [c*DW +: DW], raster order
//   relu_en         clamp negative results to zero (sampled in the last stage)
//   w_we/w_addr/w_data  weight write; address c*9+ky*3+kx, address 9*CH = bias
//   busy            a frame is in progress; weight writes are ignored
//   pxl_out         Q(FRAC) result, holds its value between results
//   valid_out       one-cycle pulse per result
//   frame_done      pulse together with the last result of a frame
module conv3x3_mc_stride_stream #(
  parameter int D      = 49,
  parameter int DW     = 32,
  parameter int FRAC   = 16,
  parameter int CH     = 3,
  parameter int STRIDE = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [CH*DW-1:0]             pxl_in,
  input  logic                         relu_en,
  input  logic                         w_we,
  input  logic [$clog2(9*CH+1)-1:0]    w_addr,
  input  logic [DW-1:0]                w_data,
  output logic                         busy,
  output logic [DW-1:0]                pxl_out,
  output logic                         valid_out,
  output logic                         frame_done
);
  localparam int NW   = 9 * CH;
  localparam int AWW  = $clog2(NW + 1);
  localparam int CW   = $clog2(D);
  localparam int PW   = 2 * DW;
  localparam int AW   = PW + AWW;
  localparam int SW   = AW + 1;
  // Last window position reached by the stride in each axis.
  localparam int LAST = D - 1 - ((D - 3) % STRIDE);

  logic [CW-1:0]          col_r, row_r;
  logic                   busy_r;
  logic                   first_s, last_s, fire_s, done_s, w_ok_s;
  logic signed [DW-1:0]   pix_s   [CH];
  logic signed [DW-1:0]   lb0_r   [CH][D];   // row r-1
  logic signed [DW-1:0]   lb1_r   [CH][D];   // row r-2
  logic signed [DW-1:0]   win_r   [CH][3][3];
  logic signed [DW-1:0]   w_r     [NW];
  logic signed [DW-1:0]   bias_r;
  logic signed [PW-1:0]   prod_r  [NW];
  logic signed [AW-1:0]   sum_s, acc_r;
  logic signed [SW-1:0]   acc_ext_s, bias_sh_s, rnd_s, sum3_s, sh_s;
  logic signed [SW-1:0]   sat_max_s, sat_min_s;
  logic [DW-1:0]          res_s;
  logic                   fire_r, fdone_r, v_p_r, d_p_r, v_a_r, d_a_r;

  assign busy = busy_r;

  // Unpack channels and decode frame position events for the current input.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      pix_s[c] = pxl_in[c*DW +: DW];
    end
    first_s = valid_in && (col_r == {CW{1'b0}}) && (row_r == {CW{1'b0}});
    last_s  = valid_in && (col_r == CW'(D-1)) && (row_r == CW'(D-1));
    fire_s  = 1'b0;
    if (valid_in && (row_r >= CW'(2)) && (col_r >= CW'(2))) begin
      // For stride 2, (x-2)%2==0 is simply "x even".
      if ((STRIDE == 1) || ((row_r[0] == 1'b0) && (col_r[0] == 1'b0))) begin
        fire_s = 1'b1;
      end else begin
        fire_s = 1'b0;
      end
    end else begin
      fire_s = 1'b0;
    end
    done_s = fire_s && (row_r == CW'(LAST)) && (col_r == CW'(LAST));
    // A write on the cycle that starts a frame loses to busy.
    w_ok_s = w_we && !busy_r && !first_s && (w_addr <= AWW'(NW));
  end

  // Raster position counters and the frame-in-progress flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r  <= {CW{1'b0}};
      row_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
    end else if (valid_in) begin
      if (col_r == CW'(D-1)) begin
        col_r <= {CW{1'b0}};
        row_r <= (row_r == CW'(D-1)) ? {CW{1'b0}} : row_r + CW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
      if (first_s) begin
        busy_r <= 1'b1;
      end else if (last_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Weight and bias register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NW; i++) begin
        w_r[i] <= {DW{1'b0}};
      end
      bias_r <= {DW{1'b0}};
    end else if (w_ok_s) begin
      for (int i = 0; i < NW; i++) begin
        if (w_addr == AWW'(i)) begin
          w_r[i] <= w_data;
        end
      end
      if (w_addr == AWW'(NW)) begin
        bias_r <= w_data;
      end
    end
  end

  // Line buffers and 3x3 window; column 2 of the window is the newest column.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int c = 0; c < CH; c++) begin
        for (int ky = 0; ky < 3; ky++) begin
          win_r[c][ky][0] <= win_r[c][ky][1];
          win_r[c][ky][1] <= win_r[c][ky][2];
        end
        win_r[c][0][2]     <= lb1_r[c][col_r];
        win_r[c][1][2]     <= lb0_r[c][col_r];
        win_r[c][2][2]     <= pix_s[c];
        lb1_r[c][col_r]    <= lb0_r[c][col_r];
        lb0_r[c][col_r]    <= pix_s[c];
      end
    end
  end

  // Stage 1 products and stage 2 accumulation, only when a window is in flight.
  always_ff @(posedge clk) begin
    if (fire_r) begin
      for (int c = 0; c < CH; c++) begin
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            prod_r[c*9+ky*3+kx] <= PW'(win_r[c][ky][kx]) * PW'(w_r[c*9+ky*3+kx]);
          end
        end
      end
    end
    if (v_p_r) begin
      acc_r <= sum_s;
    end
  end

  // Sum of products, then bias, rounding, rescale, saturation and ReLU.
  always_comb begin
    sum_s = {AW{1'b0}};
    for (int i = 0; i < NW; i++) begin
      sum_s = sum_s + {{(AW-PW){prod_r[i][PW-1]}}, prod_r[i]};
    end
    acc_ext_s = {acc_r[AW-1], acc_r};
    bias_sh_s = {{(SW-DW){bias_r[DW-1]}}, bias_r} << FRAC;
    rnd_s     = {{(SW-1){1'b0}}, 1'b1} << (FRAC - 1);
    sum3_s    = acc_ext_s + bias_sh_s + rnd_s;
    sh_s      = sum3_s >>> FRAC;
    sat_max_s = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    sat_min_s = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (sh_s > sat_max_s) begin
      res_s = sat_max_s[DW-1:0];
    end else if (sh_s < sat_min_s) begin
      res_s = sat_min_s[DW-1:0];
    end else begin
      res_s = sh_s[DW-1:0];
    end
    if (relu_en && res_s[DW-1]) begin
      res_s = {DW{1'b0}};
    end else begin
      res_s = res_s;
    end
  end

  // Valid/done pipeline and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_r     <= 1'b0;
      fdone_r    <= 1'b0;
      v_p_r      <= 1'b0;
      d_p_r      <= 1'b0;
      v_a_r      <= 1'b0;
      d_a_r      <= 1'b0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      pxl_out    <= {DW{1'b0}};
    end else begin
      fire_r     <= fire_s;
      fdone_r    <= done_s;
      v_p_r      <= fire_r;
      d_p_r      <= fdone_r;
      v_a_r      <= v_p_r;
      d_a_r      <= d_p_r;
      valid_out  <= v_a_r;
      frame_done <= v_a_r && d_a_r;
      if (v_a_r) begin
        pxl_out <= res_s;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_mc_stride_stream.sv
// Directed bench: a stride-2 and a stride-1 instance share all inputs
// (D=5, DW=32, FRAC=16, CH=3). Results are logged at the falling edge with
// their cycle number and frame_done flag, then checked against hand-derived
// values.
module tb_conv3x3_mc_stride_stream;
  logic        clk = 1'b0;
  logic        reset, valid_in, relu_en, w_we;
  logic [95:0] pxl_in;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        busy2, valid2, done2, busy1, valid1, done1;
  logic [31:0] pxl2, pxl1;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc [25];
  logic [63:0] q1[$];
  logic [63:0] q2[$];
  logic [63:0] e;

  conv3x3_mc_stride_stream #(.D(5), .DW(32), .FRAC(16), .CH(3), .STRIDE(2)) u2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .relu_en(relu_en), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy2), .pxl_out(pxl2), .valid_out(valid2), .frame_done(done2));

  conv3x3_mc_stride_stream #(.D(5), .DW(32), .FRAC(16), .CH(3), .STRIDE(1)) u1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .relu_en(relu_en), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy1), .pxl_out(pxl1), .valid_out(valid1), .frame_done(done1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Result logger: {frame_done, cycle, value}.
  always @(negedge clk) begin
    if (valid2 === 1'b1) q2.push_back({done2, cyc[30:0], pxl2});
    if (valid1 === 1'b1) q1.push_back({done1, cyc[30:0], pxl1});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] g2(input int i);
    if (i < q2.size()) return q2[i];
    else return {64{1'bx}};
  endfunction

  function automatic logic [63:0] g1(input int i);
    if (i < q1.size()) return q1[i];
    else return {64{1'bx}};
  endfunction

  // Stride-2 centre-weight results: window centres are pixels 6, 8, 16, 18.
  function automatic logic [31:0] t1v(input int i);
    case (i)
      0: return 32'h00060000;
      1: return 32'h00080000;
      2: return 32'h00100000;
      3: return 32'h00120000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int t1k(input int i);
    case (i)
      0: return 12;
      1: return 14;
      2: return 22;
      default: return 24;
    endcase
  endfunction

  function automatic logic [31:0] pix(input int mode, input int k, input int c);
    case (mode)
      0: return (c == 0) ? 32'(k << 16) : 32'h0;
      1: return 32'h00008000;
      2: return 32'h7FFF0000;
      3: return (c == 0) ? 32'((24 - k) << 16) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    tick;
    w_we = 1'b0;
  endtask

  task automatic set_all(input logic [31:0] wv, input logic [31:0] bv);
    for (int i = 0; i < 27; i++) wr(5'(i), wv);
    wr(5'd27, bv);
  endtask

  task automatic set_centre;
    set_all(32'h0, 32'h0);
    wr(5'd4, 32'h00010000);
  endtask

  task automatic clearq;
    q1.delete();
    q2.delete();
  endtask

  task automatic drain;
    valid_in = 1'b0;
    repeat (6) tick;
  endtask

  task automatic send_frame(input int mode, input bit gaps, input int npix, input bit wtest);
    for (int k = 0; k < npix; k++) begin
      valid_in = 1'b1;
      for (int c = 0; c < 3; c++) pxl_in[c*32 +: 32] = pix(mode, k, c);
      if (wtest && (k == 0 || k == 10)) begin
        w_we = 1'b1; w_addr = 5'd4;
        w_data = (k == 0) ? 32'h00030000 : 32'h00020000;
      end
      tick;
      acc_cyc[k] = cyc;
      w_we = 1'b0;
      if (wtest && k == 10) chk("t5_busy_mid", 32'(busy2), 32'd1);
      if (gaps) begin
        valid_in = 1'b0;
        pxl_in = {3{32'hDEADBEEF}};
        tick;
        tick;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic chk_t1(input string tag);
    chk({tag, "_count"}, 32'(q2.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      e = g2(i);
      chk({tag, "_val"}, e[31:0], t1v(i));
      chk({tag, "_lat"}, {1'b0, e[62:32]} - 32'(acc_cyc[t1k(i)]), 32'd3);
      chk({tag, "_done"}, 32'(e[63]), (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; relu_en = 1'b0; w_we = 1'b0;
    w_addr = 5'd0; w_data = 32'h0; pxl_in = 96'h0;
    tick; tick;
    chk("rst_busy",  32'(busy2),  32'd0);
    chk("rst_pxl",   pxl2,        32'h0);
    chk("rst_valid", 32'(valid2), 32'd0);
    chk("rst_done",  32'(done2),  32'd0);
    reset = 1'b1;
    tick;

    // T1 / T2: centre weight only; out-of-range address write must be ignored.
    set_centre;
    wr(5'd29, 32'h00050000);
    clearq;
    send_frame(0, 1'b0, 25, 1'b0);
    chk("t1_busy_end", 32'(busy2), 32'd0);
    drain;
    chk_t1("t1");
    chk("t2_count", 32'(q1.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      e = g1(i);
      chk("t2_val", e[31:0], 32'((6 + (i / 3) * 5 + (i % 3)) << 16));
      chk("t2_done", 32'(e[63]), (i == 8) ? 32'd1 : 32'd0);
    end

    // Bias -100.0 without ReLU: 6-100 = -94.0, 18-100 = -82.0.
    wr(5'd27, 32'hFF9C0000);
    relu_en = 1'b0;
    clearq;
    send_frame(0, 1'b0, 25, 1'b0);
    drain;
    e = g2(0); chk("neg_first", e[31:0], 32'hFFA20000);
    e = g2(3); chk("neg_last",  e[31:0], 32'hFFAE0000);
    relu_en = 1'b1;
    clearq;
    send_frame(0, 1'b0, 25, 1'b0);
    drain;
    chk("relu_count", 32'(q1.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      e = g1(i);
      chk("relu_val", e[31:0], 32'h0);
    end
    relu_en = 1'b0;

    // T3: 27 x (1.0 * 0.5) = 13.5.
    set_all(32'h00010000, 32'h0);
    clearq;
    send_frame(1, 1'b0, 25, 1'b0);
    drain;
    for (int i = 0; i < 4; i++) begin
      e = g2(i);
      chk("t3_val", e[31:0], 32'h000D8000);
    end
    e = g1(4); chk("t3_s1_val", e[31:0], 32'h000D8000);

    // Rounding: 27 x (1 LSB * 0.5) = 13.5 LSB rounds to 14.
    set_all(32'h00000001, 32'h0);
    clearq;
    send_frame(1, 1'b0, 25, 1'b0);
    drain;
    e = g2(0); chk("round", e[31:0], 32'h0000000E);

    // Saturation in both directions, then ReLU on negative saturation.
    set_all(32'h7FFF0000, 32'h0);
    clearq;
    send_frame(2, 1'b0, 25, 1'b0);
    drain;
    e = g2(0); chk("sat_pos", e[31:0], 32'h7FFFFFFF);
    set_all(32'h80000000, 32'h0);
    clearq;
    send_frame(2, 1'b0, 25, 1'b0);
    drain;
    e = g2(0); chk("sat_neg", e[31:0], 32'h80000000);
    relu_en = 1'b1;
    clearq;
    send_frame(2, 1'b0, 25, 1'b0);
    drain;
    e = g2(0); chk("sat_relu", e[31:0], 32'h0);
    relu_en = 1'b0;

    // T4: stalls between pixels.
    set_centre;
    clearq;
    send_frame(0, 1'b1, 25, 1'b0);
    drain;
    chk_t1("t4");

    // T5: writes during a frame (incl. on the (0,0) accept) are ignored.
    set_centre;
    clearq;
    send_frame(0, 1'b0, 25, 1'b1);
    drain;
    chk_t1("t5");

    // Back-to-back frames: second frame uses descending pixel values.
    clearq;
    send_frame(0, 1'b0, 25, 1'b0);
    send_frame(3, 1'b0, 25, 1'b0);
    drain;
    chk("b2b_count", 32'(q2.size()), 32'd8);
    for (int i = 0; i < 4; i++) begin
      e = g2(i);
      chk("b2b_f1", e[31:0], t1v(i));
      e = g2(i + 4);
      chk("b2b_f2", e[31:0], 32'(24 << 16) - t1v(i));
      chk("b2b_done", 32'(e[63]), (i == 3) ? 32'd1 : 32'd0);
    end

    // T6: reset after pixel 13; the in-flight result must be lost.
    clearq;
    send_frame(0, 1'b0, 14, 1'b0);
    reset = 1'b0;
    #1;
    chk("t6_busy",  32'(busy2),  32'd0);
    chk("t6_pxl",   pxl2,        32'h0);
    chk("t6_valid", 32'(valid2), 32'd0);
    chk("t6_done",  32'(done2),  32'd0);
    tick;
    reset = 1'b1;
    repeat (4) tick;
    chk("t6_lost", 32'(q2.size()), 32'd0);
    clearq;
    send_frame(0, 1'b0, 25, 1'b0);
    drain;
    chk("t6_zero_count", 32'(q2.size()), 32'd4);
    e = g2(3); chk("t6_zero_w", e[31:0], 32'h0);
    set_centre;
    clearq;
    send_frame(0, 1'b0, 25, 1'b0);
    drain;
    chk_t1("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
